// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings for the HI/LO multiply/divide unit.
// Op codes, FSM states and divider sizing used by hilo_unit.
package hilo_pkg;

    localparam int HILO_WIDTH     = 32;
    localparam int HILO_DIV_ITERS = 32;
    localparam int HILO_CNT_W     = $clog2(HILO_DIV_ITERS);

    localparam logic [2:0] HILO_OP_MULT  = 3'd0;
    localparam logic [2:0] HILO_OP_MULTU = 3'd1;
    localparam logic [2:0] HILO_OP_DIV   = 3'd2;
    localparam logic [2:0] HILO_OP_DIVU  = 3'd3;
    localparam logic [2:0] HILO_OP_MTHI  = 3'd4;
    localparam logic [2:0] HILO_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step: one combinational restoring-division iteration.
// Shifts in one dividend bit, trial-subtracts the divisor, yields a quotient bit.
module hilo_div_step
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nx,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor keeps shifted below 2*divisor, so bit WIDTH of trial is the borrow
    assign shifted = {rem, bit_in};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_nx  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO engine owning HI/LO.
// Divider datapath is present only when HILO_DIV_EN is defined.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               is_mul;
    logic               is_mt;
    logic               div_go;
    logic               div_last;
    logic               done_nx;
    logic               err_nx;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    assign accept = start && (state == ST_IDLE);
    assign is_mul = (op == HILO_OP_MULT) || (op == HILO_OP_MULTU);
    assign is_mt  = (op == HILO_OP_MTHI) || (op == HILO_OP_MTLO);

    assign ext_a = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a}
                              : {{WIDTH{1'b0}}, mul_a};
    assign ext_b = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b}
                              : {{WIDTH{1'b0}}, mul_b};
    assign prod  = ext_a * ext_b;

`ifdef HILO_DIV_EN
    logic                  is_div;
    logic                  b_zero;
    logic                  a_neg;
    logic                  b_neg;
    logic                  q_neg;
    logic                  r_neg;
    logic                  step_q;
    logic [HILO_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]      dvd;
    logic [WIDTH-1:0]      dvs;
    logic [WIDTH-1:0]      rem;
    logic [WIDTH-1:0]      step_rem;
    logic [WIDTH-1:0]      quo_fin;

    assign is_div   = (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
    assign b_zero   = (b == '0);
    assign a_neg    = (op == HILO_OP_DIV) && a[WIDTH-1];
    assign b_neg    = (op == HILO_OP_DIV) && b[WIDTH-1];
    assign div_go   = accept && is_div && !b_zero;
    assign div_last = (state == ST_DIV) && (cnt == '0);
    // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
    assign quo_fin  = {dvd[WIDTH-2:0], step_q};

    hilo_div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .bit_in (dvd[WIDTH-1]),
        .divisor(dvs),
        .rem_nx (step_rem),
        .q_bit  (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (div_go) begin
            dvd   <= a_neg ? -a : a;
            dvs   <= b_neg ? -b : b;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            rem   <= '0;
            cnt   <= HILO_CNT_W'(HILO_DIV_ITERS - 1);
        end else if (state == ST_DIV) begin
            rem <= step_rem;
            dvd <= quo_fin;
            cnt <= cnt - 1'b1;
        end
    end
`else
    assign div_go   = 1'b0;
    assign div_last = (state == ST_DIV);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_nx = ST_MUL;
                end else if (div_go) begin
                    state_nx = ST_DIV;
                end
            end
            ST_MUL:  state_nx = ST_IDLE;
            ST_DIV:  if (div_last) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        done_nx = 1'b0;
        err_nx  = 1'b0;
        // everything accepted that does not enter MUL/DIV finishes immediately
        if (accept && !is_mul && !div_go) begin
            done_nx = 1'b1;
            err_nx  = !is_mt;
        end
        if ((state == ST_MUL) || div_last) begin
            done_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done       <= 1'b0;
            err        <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
        end else begin
            done <= done_nx;
            err  <= err_nx;
            if (accept && is_mul) begin
                mul_a      <= a;
                mul_b      <= b;
                mul_signed <= (op == HILO_OP_MULT);
            end
            if (accept && (op == HILO_OP_MTHI)) hi <= a;
            if (accept && (op == HILO_OP_MTLO)) lo <= a;
            if (state == ST_MUL) begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end
`ifdef HILO_DIV_EN
            if (div_last) begin
                lo <= q_neg ? -quo_fin : quo_fin;
                hi <= r_neg ? -step_rem : step_rem;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed + random checks of hilo_unit against an arithmetic model.
// Expected HI/LO, latency, busy span and err come from plain 64-bit arithmetic.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    hilo_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .err  (err),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".hi"}, 64'(hi), 64'd0);
        chk({tag, ".lo"}, 64'(lo), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
    endtask

    // Reference model: result, error flag and latency from the op's arithmetic meaning
    task automatic model(input logic [2:0] o, input logic [31:0] x, y,
                         output logic [31:0] nh, nl, output logic e,
                         output int lat);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0] p;
        nh = hi_m; nl = lo_m; e = 1'b0; lat = 1;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            3'd0: begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; lat = 2; end
            3'd1: begin
                p = {32'd0, x} * {32'd0, y};
                nh = p[63:32]; nl = p[31:0]; lat = 2;
            end
            3'd2, 3'd3: begin
`ifdef HILO_DIV_EN
                if (y == 32'd0) begin
                    e = 1'b1;
                end else begin
                    if (o == 3'd3) begin
                        sx = {32'd0, x};
                        sy = {32'd0, y};
                    end
                    q = sx / sy;
                    r = sx % sy;
                    nl = q[31:0]; nh = r[31:0]; lat = 33;
                end
`else
                e = 1'b1;
`endif
            end
            3'd4: nh = x;
            3'd5: nl = x;
            default: e = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                          input string tag);
        logic [31:0] nh, nl;
        logic e;
        int lat_m, lat, nbusy;
        model(o, x, y, nh, nl, e, lat_m);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1; nbusy = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(lat_m));
        chk({tag, ".busycyc"}, 64'(nbusy), 64'(lat_m - 1));
        chk({tag, ".busy@done"}, 64'(busy), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'(e));
        chk({tag, ".hi"}, 64'(hi), 64'(nh));
        chk({tag, ".lo"}, 64'(lo), 64'(nl));
        hi_m = nh; lo_m = nl;
    endtask

    initial begin
        logic [31:0] x, y, nh, nl;
        logic e;
        int lat_m, ndone;

        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(3'd4, 32'h11, 32'h0, "mthi");
        run_op(3'd5, 32'h22, 32'h0, "mtlo");
        run_op(3'd2, 32'd123, 32'd0, "div_by_zero");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        run_op(3'd3, 32'd100, 32'd7, "divu_100by7");
        run_op(3'd3, 32'd10, 32'd3, "divu_10by3");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd6, 32'hDEAD_BEEF, 32'h1, "rsvd6");
        run_op(3'd7, 32'h1234_5678, 32'h9, "rsvd7");

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(3'($urandom_range(0, 7)), x, y, $sformatf("rand%0d", i));
        end

        // start held high through the MUL busy cycle must not apply the MTHI
        x = $urandom; y = $urandom;
        model(3'd0, x, y, nh, nl, e, lat_m);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = x; b = y;
        @(posedge clk); #1;
        chk("ign.busy", 64'(busy), 64'd1);
        op = 3'd4; a = ~x;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign.done", 64'(done), 64'd1);
        chk("ign.err", 64'(err), 64'd0);
        chk("ign.hi", 64'(hi), 64'(nh));
        chk("ign.lo", 64'(lo), 64'(nl));
        @(posedge clk); #1;
        chk("ign.pulse", 64'(done), 64'd0);
        chk("ign.hi2", 64'(hi), 64'(nh));
        hi_m = nh; lo_m = nl;

        // reset while a MUL is in flight
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = $urandom | 32'h1; b = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rstmul.busy", 64'(busy), 64'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("rstmul");
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("rstmul.nodone", 64'(ndone), 64'd0);
        hi_m = '0; lo_m = '0;

`ifdef HILO_DIV_EN
        run_op(3'd4, 32'h5555_AAAA, 32'h0, "pre_hi");
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rstdiv.busy5", 64'(busy), 64'd1);
        chk("rstdiv.err5", 64'(err), 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("rstdiv");
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("rstdiv.nodone", 64'(ndone), 64'd0);
        chk("rstdiv.hi", 64'(hi), 64'd0);
        hi_m = '0; lo_m = '0;
`endif

        run_op(3'd5, 32'hCAFE_F00D, 32'h0, "final_mtlo");
        @(posedge clk); #1;
        chk("final.done_low", 64'(done), 64'd0);
        chk("final.err_low", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
